// File: rtl/ddr2_rd_data_checker.sv
// Read-data checker for the DDR2 test path: compares each double-rate read word
// against the expected pattern per lane and edge, with counters and first-failure capture.
module ddr2_rd_data_checker #(
    parameter int DQ_WIDTH   = 32,
    parameter int LANE_WIDTH = 8,
    parameter int CNT_WIDTH  = 16,
    parameter int BURST_LEN  = 4,
    localparam int NL = DQ_WIDTH / LANE_WIDTH,
    localparam int BW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  read_data_valid,
    input  logic [2*DQ_WIDTH-1:0] read_data_fifo_out,
    input  logic [2*DQ_WIDTH-1:0] app_compare_data,
    input  logic [NL-1:0]         lane_mask,
    input  logic                  sticky_mode,
    input  logic                  clear,
    output logic                  error,
    output logic [NL-1:0]         lane_err_rising,
    output logic [NL-1:0]         lane_err_falling,
    output logic [CNT_WIDTH-1:0]  cmp_count,
    output logic [CNT_WIDTH-1:0]  err_count,
    output logic                  first_err_valid,
    output logic [2*DQ_WIDTH-1:0] first_err_data,
    output logic [2*DQ_WIDTH-1:0] first_err_expected,
    output logic [BW-1:0]         first_err_beat
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX   = {CNT_WIDTH{1'b1}};
    localparam logic [BW-1:0]        BEAT_LAST = BW'(BURST_LEN - 1);

    function automatic logic [NL-1:0] lane_mismatch(
        input logic [DQ_WIDTH-1:0] act,
        input logic [DQ_WIDTH-1:0] exp,
        input logic [NL-1:0]       mask,
        input logic                valid
    );
        logic [NL-1:0] mis;
        mis = {NL{1'b0}};
        for (int i = 0; i < NL; i++) begin
            mis[i] = valid & ~mask[i] &
                     (act[i*LANE_WIDTH +: LANE_WIDTH] != exp[i*LANE_WIDTH +: LANE_WIDTH]);
        end
        return mis;
    endfunction

    logic                  s1_valid_q, s1_valid_d;
    logic [2*DQ_WIDTH-1:0] s1_rd_q, s1_rd_d, s1_exp_q, s1_exp_d;
    logic [NL-1:0]         s1_mask_q, s1_mask_d;
    logic [BW-1:0]         s1_beat_q, s1_beat_d, beat_q, beat_d;

    logic                  s2_valid_q, s2_valid_d, s2_any_q, s2_any_d;
    logic [NL-1:0]         s2_mis_r_q, s2_mis_r_d, s2_mis_f_q, s2_mis_f_d;
    logic [2*DQ_WIDTH-1:0] s2_rd_q, s2_rd_d, s2_exp_q, s2_exp_d;
    logic [BW-1:0]         s2_beat_q, s2_beat_d;

    logic                  error_q, error_d, fev_q, fev_d;
    logic [NL-1:0]         ler_q, ler_d, lef_q, lef_d;
    logic [CNT_WIDTH-1:0]  cmp_q, cmp_d, errc_q, errc_d;
    logic [2*DQ_WIDTH-1:0] fe_data_q, fe_data_d, fe_exp_q, fe_exp_d;
    logic [BW-1:0]         fe_beat_q, fe_beat_d;

    // S1 capture and beat index; the word gets the index held before its edge
    always_comb begin
        s1_valid_d = read_data_valid;
        s1_rd_d    = read_data_fifo_out;
        s1_exp_d   = app_compare_data;
        s1_mask_d  = lane_mask;
        s1_beat_d  = beat_q;
        if (clear) begin
            beat_d = {BW{1'b0}};
        end else if (read_data_valid) begin
            beat_d = (beat_q == BEAT_LAST) ? {BW{1'b0}} : beat_q + BW'(1);
        end else begin
            beat_d = beat_q;
        end
    end

    // S2 per-lane compare of both edges
    always_comb begin
        s2_valid_d = s1_valid_q;
        s2_mis_r_d = lane_mismatch(s1_rd_q[2*DQ_WIDTH-1:DQ_WIDTH], s1_exp_q[2*DQ_WIDTH-1:DQ_WIDTH],
                                   s1_mask_q, s1_valid_q);
        s2_mis_f_d = lane_mismatch(s1_rd_q[DQ_WIDTH-1:0], s1_exp_q[DQ_WIDTH-1:0],
                                   s1_mask_q, s1_valid_q);
        s2_any_d   = (|s2_mis_r_d) | (|s2_mis_f_d);
        s2_rd_d    = s1_rd_q;
        s2_exp_d   = s1_exp_q;
        s2_beat_d  = s1_beat_q;
    end

    // S3 flags, saturating counters and first-failure capture; clear drops the arriving word
    always_comb begin
        error_d   = error_q;
        ler_d     = ler_q;
        lef_d     = lef_q;
        cmp_d     = cmp_q;
        errc_d    = errc_q;
        fev_d     = fev_q;
        fe_data_d = fe_data_q;
        fe_exp_d  = fe_exp_q;
        fe_beat_d = fe_beat_q;
        if (clear) begin
            error_d   = 1'b0;
            ler_d     = {NL{1'b0}};
            lef_d     = {NL{1'b0}};
            cmp_d     = {CNT_WIDTH{1'b0}};
            errc_d    = {CNT_WIDTH{1'b0}};
            fev_d     = 1'b0;
            fe_data_d = {(2*DQ_WIDTH){1'b0}};
            fe_exp_d  = {(2*DQ_WIDTH){1'b0}};
            fe_beat_d = {BW{1'b0}};
        end else begin
            if (sticky_mode) begin
                error_d = error_q | s2_any_q;
                ler_d   = ler_q | s2_mis_r_q;
                lef_d   = lef_q | s2_mis_f_q;
            end else begin
                error_d = s2_any_q;
                ler_d   = s2_mis_r_q;
                lef_d   = s2_mis_f_q;
            end
            if (s2_valid_q && (cmp_q != CNT_MAX)) begin
                cmp_d = cmp_q + CNT_WIDTH'(1);
            end else begin
                cmp_d = cmp_q;
            end
            if (s2_any_q && (errc_q != CNT_MAX)) begin
                errc_d = errc_q + CNT_WIDTH'(1);
            end else begin
                errc_d = errc_q;
            end
            if (s2_any_q && !fev_q) begin
                fev_d     = 1'b1;
                fe_data_d = s2_rd_q;
                fe_exp_d  = s2_exp_q;
                fe_beat_d = s2_beat_q;
            end else begin
                fev_d     = fev_q;
            end
        end
    end

    // Pipeline and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            s1_valid_q <= 1'b0;
            s1_rd_q    <= {(2*DQ_WIDTH){1'b0}};
            s1_exp_q   <= {(2*DQ_WIDTH){1'b0}};
            s1_mask_q  <= {NL{1'b0}};
            s1_beat_q  <= {BW{1'b0}};
            beat_q     <= {BW{1'b0}};
            s2_valid_q <= 1'b0;
            s2_any_q   <= 1'b0;
            s2_mis_r_q <= {NL{1'b0}};
            s2_mis_f_q <= {NL{1'b0}};
            s2_rd_q    <= {(2*DQ_WIDTH){1'b0}};
            s2_exp_q   <= {(2*DQ_WIDTH){1'b0}};
            s2_beat_q  <= {BW{1'b0}};
            error_q    <= 1'b0;
            ler_q      <= {NL{1'b0}};
            lef_q      <= {NL{1'b0}};
            cmp_q      <= {CNT_WIDTH{1'b0}};
            errc_q     <= {CNT_WIDTH{1'b0}};
            fev_q      <= 1'b0;
            fe_data_q  <= {(2*DQ_WIDTH){1'b0}};
            fe_exp_q   <= {(2*DQ_WIDTH){1'b0}};
            fe_beat_q  <= {BW{1'b0}};
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_rd_q    <= s1_rd_d;
            s1_exp_q   <= s1_exp_d;
            s1_mask_q  <= s1_mask_d;
            s1_beat_q  <= s1_beat_d;
            beat_q     <= beat_d;
            s2_valid_q <= s2_valid_d;
            s2_any_q   <= s2_any_d;
            s2_mis_r_q <= s2_mis_r_d;
            s2_mis_f_q <= s2_mis_f_d;
            s2_rd_q    <= s2_rd_d;
            s2_exp_q   <= s2_exp_d;
            s2_beat_q  <= s2_beat_d;
            error_q    <= error_d;
            ler_q      <= ler_d;
            lef_q      <= lef_d;
            cmp_q      <= cmp_d;
            errc_q     <= errc_d;
            fev_q      <= fev_d;
            fe_data_q  <= fe_data_d;
            fe_exp_q   <= fe_exp_d;
            fe_beat_q  <= fe_beat_d;
        end
    end

    assign error              = error_q;
    assign lane_err_rising    = ler_q;
    assign lane_err_falling   = lef_q;
    assign cmp_count          = cmp_q;
    assign err_count          = errc_q;
    assign first_err_valid    = fev_q;
    assign first_err_data     = fe_data_q;
    assign first_err_expected = fe_exp_q;
    assign first_err_beat     = fe_beat_q;

endmodule

// File: tb/tb_ddr2_rd_data_checker.sv
// Bench for ddr2_rd_data_checker: table-driven bursts feeding a scoreboard queue,
// plus hand-written clear, saturation and mid-burst reset sequences.
module tb_ddr2_rd_data_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, read_data_valid, sticky_mode, clear;
    logic [63:0] rdf, acd;
    logic [3:0]  lane_mask;
    logic        error, first_err_valid;
    logic [3:0]  lane_err_rising, lane_err_falling, cmp_count, err_count;
    logic [63:0] first_err_data, first_err_expected;
    logic [1:0]  first_err_beat;

    ddr2_rd_data_checker #(.DQ_WIDTH(32), .LANE_WIDTH(8), .CNT_WIDTH(4), .BURST_LEN(4)) dut (
        .clk(clk), .reset(reset), .read_data_valid(read_data_valid),
        .read_data_fifo_out(rdf), .app_compare_data(acd), .lane_mask(lane_mask),
        .sticky_mode(sticky_mode), .clear(clear), .error(error),
        .lane_err_rising(lane_err_rising), .lane_err_falling(lane_err_falling),
        .cmp_count(cmp_count), .err_count(err_count), .first_err_valid(first_err_valid),
        .first_err_data(first_err_data), .first_err_expected(first_err_expected),
        .first_err_beat(first_err_beat)
    );

    typedef struct {
        logic [63:0] rd;
        logic [63:0] ex;
        logic [3:0]  mask;
        logic [3:0]  mr;
        logic [3:0]  mf;
    } vec_t;

    typedef struct {
        logic [3:0]  mr;
        logic [3:0]  mf;
        logic [1:0]  beat;
        logic [63:0] rd;
        logic [63:0] ex;
        int          due;
    } item_t;

    vec_t  tbl [8];
    item_t sb[$];

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int pulse_cnt = 0;
    logic [3:0]  cur_mr, cur_mf;
    logic        m_err, m_fev;
    logic [3:0]  m_lr, m_lf, m_cmp, m_errc;
    logic [63:0] m_fd, m_fe;
    logic [1:0]  m_fb, m_beat;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic model_zero();
        m_err = 1'b0; m_fev = 1'b0; m_lr = 4'd0; m_lf = 4'd0;
        m_cmp = 4'd0; m_errc = 4'd0; m_fd = 64'd0; m_fe = 64'd0; m_fb = 2'd0;
    endtask

    // One clock: sample the driven inputs, advance the model, then compare every output
    task automatic tick();
        item_t it;
        logic  have, rst_e, clr_e, stk, v, any;
        logic [3:0] mr, mf;
        rst_e = !reset; clr_e = clear; stk = sticky_mode; v = read_data_valid;
        @(posedge clk);
        #1;
        if (rst_e) begin
            sb.delete();
            model_zero();
            m_beat = 2'd0;
        end else begin
            have = 1'b0;
            if (sb.size() > 0 && sb[0].due == cyc) begin
                it = sb.pop_front();
                have = 1'b1;
            end
            if (clr_e) begin
                model_zero();
            end else begin
                mr  = have ? it.mr : 4'd0;
                mf  = have ? it.mf : 4'd0;
                any = (|mr) | (|mf);
                if (stk) begin
                    m_lr = m_lr | mr; m_lf = m_lf | mf; m_err = m_err | any;
                end else begin
                    m_lr = mr; m_lf = mf; m_err = any;
                end
                if (have) begin
                    if (m_cmp != 4'hF) m_cmp = m_cmp + 4'd1;
                    if (any && m_errc != 4'hF) m_errc = m_errc + 4'd1;
                    if (any && !m_fev) begin
                        m_fev = 1'b1; m_fd = it.rd; m_fe = it.ex; m_fb = it.beat;
                    end
                end
            end
            if (v) begin
                it.mr = cur_mr; it.mf = cur_mf; it.beat = m_beat;
                it.rd = rdf; it.ex = acd; it.due = cyc + 2;
                sb.push_back(it);
            end
            if (clr_e) m_beat = 2'd0;
            else if (v) m_beat = m_beat + 2'd1;
        end
        cyc++;
        if (error === 1'b1) pulse_cnt++;
        check("error", error, m_err);
        check("lane_err_rising", lane_err_rising, m_lr);
        check("lane_err_falling", lane_err_falling, m_lf);
        check("cmp_count", cmp_count, m_cmp);
        check("err_count", err_count, m_errc);
        check("first_err_valid", first_err_valid, m_fev);
        check("first_err_data", first_err_data, m_fd);
        check("first_err_expected", first_err_expected, m_fe);
        check("first_err_beat", first_err_beat, m_fb);
    endtask

    task automatic drive(input logic [63:0] rd, input logic [63:0] ex, input logic [3:0] mask,
                         input logic [3:0] mr, input logic [3:0] mf);
        read_data_valid = 1'b1; rdf = rd; acd = ex; lane_mask = mask;
        cur_mr = mr; cur_mf = mf;
        tick();
        read_data_valid = 1'b0; lane_mask = 4'd0; cur_mr = 4'd0; cur_mf = 4'd0;
    endtask

    task automatic idle(input int n);
        read_data_valid = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_clear();
        clear = 1'b1;
        idle(1);
        clear = 1'b0;
    endtask

    task automatic build(input int sc);
        for (int j = 0; j < 8; j++) begin
            tbl[j].ex = {8'h10 + 8'(j), 8'hA5, 8'h20, 8'h30 + 8'(j),
                         8'h40, 8'h50 + 8'(j), 8'h60, 8'h70 + 8'(j)};
            tbl[j].rd = tbl[j].ex;
            tbl[j].mask = 4'd0; tbl[j].mr = 4'd0; tbl[j].mf = 4'd0;
        end
        case (sc)
            1: begin tbl[5].rd[55:48] = 8'h5A; tbl[5].mr = 4'b0100; end
            2: begin tbl[5].rd[55:48] = 8'h5A; tbl[5].mask = 4'b0100; end
            3: begin
                tbl[1].rd[7:0] = ~tbl[1].ex[7:0]; tbl[1].mf = 4'b0001;
                tbl[3].rd[7:0] = ~tbl[3].ex[7:0]; tbl[3].mf = 4'b0001;
            end
            default: ;
        endcase
    endtask

    task automatic run_table(input int sc);
        build(sc);
        for (int j = 0; j < 8; j++) drive(tbl[j].rd, tbl[j].ex, tbl[j].mask, tbl[j].mr, tbl[j].mf);
        idle(3);
    endtask

    initial begin
        logic [63:0] bad;
        reset = 1'b0; read_data_valid = 1'b0; sticky_mode = 1'b1; clear = 1'b0;
        rdf = 64'd0; acd = 64'd0; lane_mask = 4'd0; cur_mr = 4'd0; cur_mf = 4'd0;
        model_zero(); m_beat = 2'd0;
        idle(2);
        reset = 1'b1;
        idle(1);

        run_table(0);
        check("clean cmp_count", cmp_count, 64'd8);
        check("clean err_count", err_count, 64'd0);
        check("clean error", error, 64'd0);
        check("clean first_err_valid", first_err_valid, 64'd0);
        do_clear();

        run_table(1);
        check("inj error", error, 64'd1);
        check("inj lane_err_rising", lane_err_rising, 64'h4);
        check("inj lane_err_falling", lane_err_falling, 64'h0);
        check("inj err_count", err_count, 64'd1);
        check("inj first_err_beat", first_err_beat, 64'd1);
        check("inj first_err_data", first_err_data, tbl[5].rd);
        sticky_mode = 1'b0;
        idle(1);
        check("sticky drop error", error, 64'd0);
        check("sticky drop lane_err_rising", lane_err_rising, 64'h0);
        sticky_mode = 1'b1;
        do_clear();

        run_table(2);
        check("mask error", error, 64'd0);
        check("mask err_count", err_count, 64'd0);
        check("mask cmp_count", cmp_count, 64'd8);
        do_clear();

        sticky_mode = 1'b0;
        pulse_cnt = 0;
        run_table(3);
        check("pulse count", pulse_cnt, 64'd2);
        check("pulse error", error, 64'd0);
        check("pulse err_count", err_count, 64'd2);
        check("pulse first_err_beat", first_err_beat, 64'd1);
        check("pulse first_err_data", first_err_data, tbl[1].rd);
        sticky_mode = 1'b1;
        do_clear();

        build(0);
        bad = tbl[0].ex;
        bad[39:32] = ~bad[39:32];
        for (int j = 0; j < 20; j++) drive(bad, tbl[0].ex, 4'd0, 4'b0001, 4'd0);
        idle(3);
        check("sat cmp_count", cmp_count, 64'hF);
        check("sat err_count", err_count, 64'hF);
        do_clear();
        check("clear cmp_count", cmp_count, 64'd0);
        check("clear err_count", err_count, 64'd0);
        check("clear error", error, 64'd0);
        check("clear lane_err_rising", lane_err_rising, 64'd0);
        check("clear first_err_valid", first_err_valid, 64'd0);
        check("clear first_err_data", first_err_data, 64'd0);

        drive(bad, tbl[0].ex, 4'd0, 4'b0001, 4'd0);
        drive(bad, tbl[0].ex, 4'd0, 4'b0001, 4'd0);
        reset = 1'b0;
        idle(1);
        reset = 1'b1;
        check("rst error", error, 64'd0);
        check("rst cmp_count", cmp_count, 64'd0);
        check("rst first_err_valid", first_err_valid, 64'd0);
        idle(3);
        check("rst inflight cmp_count", cmp_count, 64'd0);
        drive(bad, tbl[0].ex, 4'd0, 4'b0001, 4'd0);
        idle(3);
        check("post rst cmp_count", cmp_count, 64'd1);
        check("post rst first_err_valid", first_err_valid, 64'd1);
        check("post rst first_err_beat", first_err_beat, 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
